// File: rtl/key_event_queue.sv
// key_event_queue: pulls key codes from a UART RX FIFO, drops NUL bytes and
//   held-key repeats, and buffers the survivors in a small FIFO for a consumer.
// Ports: clk/rst (async active-high); rx_empty/r_data/rd_uart talk to the UART
//   FIFO; key_valid/key_data/key_ready form the consumer handshake; fifo_count
//   and overflow (sticky) report queue status.
// Latency: rd_uart to key_valid is 2 cycles on an empty queue. Intake runs at
//   most one byte per 2 cycles. When the queue is full, a new key is dropped
//   unless the consumer pops in the same cycle.
module key_event_queue #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int HOLD_CYC  = 1000000,
  parameter int FILTER_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_empty,
  input  logic [DATA_W-1:0]          r_data,
  output logic                       rd_uart,
  output logic                       key_valid,
  output logic [DATA_W-1:0]          key_data,
  input  logic                       key_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] last_key_q, last_key_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic in_check;
  logic filter_hit;
  logic candidate;
  logic full;
  logic pop;
  logic push;

  // The strobe is combinational from the FSM state. It is gated by rst so the
  // UART FIFO is never popped while the block is held in reset.
  assign rd_uart    = ~rst & (state_q == ST_IDLE) & ~rx_empty;

  assign key_valid  = (count_q != '0);
  assign key_data   = key_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  assign in_check   = (state_q == ST_CHECK);
  assign full       = (count_q == CNT_FULL);
  assign pop        = key_valid & key_ready;

  // A repeat is suppressed only while the hold window from the last accepted
  // key is still open. A different code never matches last_key, so it passes.
  assign filter_hit = (FILTER_EN != 0) && (cap_q == last_key_q) && (hold_cnt_q != '0);
  assign candidate  = in_check && (cap_q != '0) && !filter_hit;

  // On a full queue the push succeeds only if a pop frees the slot in the
  // same cycle. The queue is never empty while full, so the pop is real.
  assign push       = candidate && (!full || pop);

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          cap_d   = r_data;
          state_d = ST_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_key_d = last_key_q;
    hold_cnt_d = hold_cnt_q;
    overflow_d = overflow_q;
    if (push) begin
      last_key_d = cap_q;
      hold_cnt_d = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end
    if (candidate && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = cap_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      last_key_q <= '0;
      hold_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      last_key_q <= last_key_d;
      hold_cnt_q <= hold_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (DEPTH=4, HOLD_CYC=10, filter enabled).
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  key_event_queue #(
    .DATA_W(8), .DEPTH(4), .HOLD_CYC(10), .FILTER_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_empty = 1'b1; key_ready = 1'b0; r_data = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one byte to the UART side and checks the pop strobe lasts one cycle.
  // Returns just after the pop edge, i.e. early in the CHECK cycle.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge clk);
    rx_empty = 1'b0; r_data = b;
    #1;
    waited = 0;
    while (rd_uart !== 1'b1 && waited < 4) begin
      @(negedge clk); #1;
      waited++;
    end
    n_tests++;
    if (rd_uart !== 1'b1) begin
      n_fail++; $display("FAIL send_rd_uart_hi: got %b expected 1 (byte %h)", rd_uart, b);
    end
    @(posedge clk); #1;
    rx_empty = 1'b1; r_data = 8'h00;
    n_tests++;
    if (rd_uart !== 1'b0) begin
      n_fail++; $display("FAIL send_rd_uart_lo: got %b expected 0 (byte %h)", rd_uart, b);
    end
  endtask

  task automatic drain_expect(input logic [7:0] b);
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b1 || key_data !== b) begin
      n_fail++; $display("FAIL drain_head: got valid=%b data=%h expected valid=1 data=%h", key_valid, key_data, b);
    end
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_empty = 1'b0; r_data = 8'h42;
    #2;
    n_tests++;
    if ({rd_uart, key_valid, key_data, fifo_count, overflow} !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs: got rd=%b v=%b d=%h c=%0d ovf=%b expected all 0",
                         rd_uart, key_valid, key_data, fifo_count, overflow);
    end
    rx_empty = 1'b1;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    rx_empty = 1'b0; r_data = 8'h77;
    #1;
    n_tests++;
    if (rd_uart !== 1'b1 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_strobe: got rd=%b v=%b expected rd=1 v=0", rd_uart, key_valid);
    end
    @(posedge clk); #1;
    rx_empty = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rd_uart !== 1'b0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_cycle1: got rd=%b v=%b expected rd=0 v=0", rd_uart, key_valid);
    end
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b1 || key_data !== 8'h77 || fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL single_cycle2: got v=%b d=%h c=%0d expected v=1 d=77 c=1", key_valid, key_data, fifo_count);
    end
  endtask

  task automatic test_filter();
    do_reset();
    send_byte(8'h77);
    repeat (4) @(posedge clk);
    send_byte(8'h77);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd1 || key_data !== 8'h77) begin
      n_fail++; $display("FAIL filter_repeat: got c=%0d d=%h expected c=1 d=77", fifo_count, key_data);
    end
    repeat (12) @(posedge clk);
    send_byte(8'h77);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd2) begin
      n_fail++; $display("FAIL filter_expired: got c=%0d expected 2", fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h77);
    send_byte(8'h73);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd2) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 2", fifo_count);
    end
    drain_expect(8'h77);
    drain_expect(8'h73);
    @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_empty: got c=%0d v=%b expected c=0 v=0", fifo_count, key_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full: got c=%0d ovf=%b expected c=4 ovf=1", fifo_count, overflow);
    end
    drain_expect(8'h11); drain_expect(8'h22);
    drain_expect(8'h33); drain_expect(8'h44);
    @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got c=%0d ovf=%b expected c=0 ovf=1", fifo_count, overflow);
    end

    // Fifth key arrives with a pop in the same cycle: it must be accepted.
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pop_push: got c=%0d ovf=%b expected c=4 ovf=0", fifo_count, overflow);
    end
    drain_expect(8'h22); drain_expect(8'h33);
    drain_expect(8'h44); drain_expect(8'h55);
  endtask

  task automatic test_zero();
    do_reset();
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_byte: got c=%0d v=%b expected c=0 v=0", fifo_count, key_valid);
    end
  endtask

  task automatic test_empty_ready();
    do_reset();
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    key_ready = 1'b0;
    send_byte(8'h3C);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd1 || key_data !== 8'h3C) begin
      n_fail++; $display("FAIL empty_ready: got c=%0d d=%h expected c=1 d=3c", fifo_count, key_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd3) begin
      n_fail++; $display("FAIL mid_prefill: got c=%0d expected 3", fifo_count);
    end
    rst = 1'b1; rx_empty = 1'b0; r_data = 8'h5A;
    #1;
    n_tests++;
    if ({rd_uart, key_valid, key_data, fifo_count, overflow} !== 13'd0) begin
      n_fail++; $display("FAIL mid_reset: got rd=%b v=%b d=%h c=%0d ovf=%b expected all 0",
                         rd_uart, key_valid, key_data, fifo_count, overflow);
    end
    @(negedge clk);
    rst = 1'b0; rx_empty = 1'b1;
    send_byte(8'h5A);
    repeat (2) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd1 || key_data !== 8'h5A) begin
      n_fail++; $display("FAIL mid_after: got c=%0d d=%h expected c=1 d=5a", fifo_count, key_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_back_to_back();
    test_overflow();
    test_zero();
    test_empty_ready();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of a key code byte.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, minimum 2.
REQ-003 SHALL have parameter HOLD_CYC, default 1000000, meaning repeat-suppression window in clk cycles; minimum 1.
REQ-004 SHALL have parameter FILTER_EN, default 1, meaning 1 enables repeat suppression and 0 disables it.
REQ-005 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port rx_empty, input, 1, meaning the UART receive FIFO is empty.
REQ-008 SHALL have port r_data, input, DATA_W, meaning the UART FIFO head byte (first-word-fall-through), valid while rx_empty=0.
REQ-009 SHALL have port rd_uart, output, 1, meaning a one-cycle pop strobe to the UART FIFO.
REQ-010 SHALL have port key_valid, output, 1, meaning key_data holds a queued key.
REQ-011 SHALL have port key_data, output, DATA_W, meaning the queue head key code.
REQ-012 SHALL have port key_ready, input, 1, meaning the consumer accepts key_data this cycle.
REQ-013 SHALL have port fifo_count, output, clog2(DEPTH)+1, meaning the number of queued entries.
REQ-014 SHALL have port overflow, output, 1, meaning a sticky flag that a key was lost because the queue was full.

Function
REQ-015 SHALL implement an intake FSM with states IDLE and CHECK.
REQ-016 In IDLE with rx_empty=0, SHALL drive rd_uart=1 for exactly that cycle, register r_data, and go to CHECK; otherwise SHALL stay in IDLE with rd_uart=0.
REQ-017 In CHECK, SHALL always return to IDLE next cycle, so intake is at most one byte per 2 cycles.
REQ-018 In CHECK, SHALL discard a captured byte equal to 0.
REQ-019 In CHECK with FILTER_EN=1, SHALL discard a byte equal to last_key while hold_cnt is nonzero.
REQ-020 In CHECK, SHALL push a byte that is not discarded if the queue is not full, then set last_key to that byte and load hold_cnt with HOLD_CYC.
REQ-021 If a byte reaches the push point with the queue full and no pop in the same cycle, SHALL drop it, set overflow=1, and leave last_key and hold_cnt unchanged.
REQ-022 Full queue with a simultaneous pop in the push cycle: SHALL accept the push; fifo_count stays DEPTH.
REQ-023 SHALL decrement hold_cnt by 1 each cycle when nonzero, saturating at 0; a reload has priority over the decrement.
REQ-024 A different key SHALL always pass the filter regardless of hold_cnt.
REQ-025 key_valid SHALL be (fifo_count != 0); key_data SHALL equal the head entry combinationally from registers.
REQ-026 SHALL pop on key_valid & key_ready; key_ready while empty SHALL have no effect.
REQ-027 Simultaneous push and pop on a non-full, non-empty queue SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-028 Simultaneous push and pop on an empty queue SHALL NOT be possible; the push into an empty queue SHALL make key_valid high the next cycle.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 Latency from rd_uart to key_valid on an empty queue SHALL be 2 cycles.
REQ-031 overflow SHALL clear only on reset.

Reset
REQ-032 While rst=1, SHALL hold: FSM=IDLE, rd_uart=0, key_valid=0, key_data=0, fifo_count=0, overflow=0, last_key=0, hold_cnt=0, pointers=0.
REQ-033 Reset asserted mid-operation SHALL lose all queued and captured bytes; the first rising edge after release SHALL act as IDLE.

Verification
REQ-034 Bench SHALL cover: rx_empty=0 with r_data=0x77 once, key_ready=0 -> rd_uart pulses 1 cycle; 2 cycles later key_valid=1, key_data=0x77, fifo_count=1.
REQ-035 Bench SHALL cover: FILTER_EN=1, HOLD_CYC=10, 0x77 then 0x77 again 4 cycles later -> second byte popped but discarded, fifo_count=1; 0x77 after 12 more cycles -> accepted.
REQ-036 Bench SHALL cover: 0x77 then 0x73 back-to-back -> both queued in order, head 0x77 then 0x73.
REQ-037 Bench SHALL cover: DEPTH=4, key_ready=0, 5 distinct keys -> fifo_count=4, overflow=1, first 4 keys drain in order; with key_ready=1 on the 5th push cycle -> accepted, overflow=0.
REQ-038 Bench SHALL cover: byte 0x00 -> rd_uart pulses, nothing queued.
REQ-039 Bench SHALL cover: rst pulse with 3 entries queued -> all outputs 0 immediately; the next key after release is queued normally.
